reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Consumes the board/bench clock and raw reset; produces per-domain reset releases in sequence.
//  Stage 1: synchronises reset release (asynchronous assert, synchronous deassert).
//  Stage 2: holds all domains in reset, then releases them in index order with programmable gaps.
//  Also accepts a soft-reset request handshake once sequencing is done.
// PARAMETERS
//  STAGES       2   synchroniser flop depth (>=2)
//  NUM_OUT      3   number of reset domains driven (>=1)
//  HOLD_CYCLES  16  cycles all domains stay asserted after synchronised release (>=1)
//  GAP_CYCLES   4   cycles between successive domain releases (>=1)
// PORTS
//  clk          in   1        single clock
//  rst          in   1        asynchronous, active-low reset
//  soft_rst_req in   1        level request for soft reset, held until ack
//  soft_rst_ack out  1        one-cycle pulse: soft reset accepted
//  rst_out      out  NUM_OUT  active-high reset per domain
//  ready        out  1        all domains released
// BEHAVIOUR
//  - Reset values (rst low): rst_out = all 1s, ready = 0, soft_rst_ack = 0.
//    Synchroniser chain is cleared; FSM state = HOLD; counters = 0. All take effect immediately, no clock.
//  - Synchroniser: rst_sync rises STAGES rising edges after rst goes high.
//    Count edges from the first edge that samples rst=1.
//  - FSM states:
//    - HOLD: count HOLD_CYCLES, then go to RELEASE.
//    - RELEASE: idx starts at 0. Clear rst_out[idx]; wait GAP_CYCLES; increment idx.
//      After idx=NUM_OUT-1 is cleared, go to DONE.
//    - DONE: ready = 1.
//    - SOFT: see the optional feature below.
//  - Timing from power-on reset release:
//    - rst_out[0] falls on edge STAGES+HOLD_CYCLES.
//    - rst_out[i] falls GAP_CYCLES edges after rst_out[i-1].
//    - ready rises on the same edge rst_out[NUM_OUT-1] falls.
//    - With NUM_OUT=1, ready rises together with rst_out[0].
//  - Released bits stay 0 until the next reset/soft reset; rst_out is monotonic within a sequence.
//  - Counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1); counters never wrap.
//  - Soft reset: sampled only in DONE.
//    - On an edge with soft_rst_req=1: rst_out = all 1s, ready = 0, soft_rst_ack = 1 for that one cycle.
//    - FSM then enters HOLD with counters cleared; no synchroniser delay applies.
//    - rst_out[0] falls HOLD_CYCLES edges after the ack edge.
//  - soft_rst_req while not in DONE: ignored, no ack. Requester keeps it high; it is served on reaching DONE.
//  - soft_rst_req still high at DONE after a served request: triggers another soft reset (level sensitive).
//  - rst asserted mid-sequence or mid-soft-reset: immediate return to reset values.
//    Any pending ack is dropped.
//  - rst glitch shorter than a clock period: still fully resets; release re-synchronised.
// CONFIGURATION
//  RESET_SEQ_REVERSE_EN defined:
//    - Soft reset enters SOFT instead of asserting all domains at once.
//    - ready drops and rst_out[NUM_OUT-1] asserts on the request edge.
//    - Each lower index asserts GAP_CYCLES later.
//    - soft_rst_ack pulses on the edge rst_out[0] asserts; then HOLD as above.
//    - rst low during SOFT: immediate all-asserted reset values.
//  RESET_SEQ_REVERSE_EN undefined:
//    - No SOFT state; all domains assert simultaneously with ack on the request edge.
// TESTING (defaults: STAGES=2 NUM_OUT=3 HOLD=16 GAP=4)
//  1. Power-on: rst low 5 cycles, then high -> rst_out 3'b111 through edge 17;
//     rst_out[0]=0 @18, [1]=0 @22, [2]=0 @26, ready=1 @26.
//  2. rst pulled low at edge 20 (mid-release) -> rst_out=3'b111, ready=0 immediately, no clock;
//     re-release repeats test 1 timing.
//  3. In DONE, soft_rst_req=1 -> ack=1 one cycle, rst_out=3'b111, ready=0 same edge;
//     rst_out[0] falls 16 edges after ack.
//  4. soft_rst_req raised during HOLD -> no ack until DONE;
//     ack fires on the edge ready would first be 1.
//  5. RESET_SEQ_REVERSE_EN, soft req in DONE -> rst_out 3'b100 @0, 3'b110 @4, 3'b111 @8;
//     ack @8; rst_out[0] falls @24.
//  6. rst glitch low for 2ns between edges -> full reset values;
//     rst_out[0] release at edge 18 after rst returns high.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Soft-reset request/acknowledge handshake between a requester and the sequencer.
// Signals: soft_rst_req (level, held until ack), soft_rst_ack (one-cycle pulse).
interface reset_sequencer_if;
  logic soft_rst_req;
  logic soft_rst_ack;

  modport master (
    output soft_rst_req,
    input  soft_rst_ack
  );

  modport slave (
    input  soft_rst_req,
    output soft_rst_ack
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronised release, hold, then per-domain release in order.
// Ports: clk, rst (async active-low), soft_if (slave: soft_rst_req/ack),
//        rst_out[NUM_OUT] (active-high domain resets), ready (all released).
// Optional: RESET_SEQ_REVERSE_EN staggers soft-reset assertion high-to-low.
module reset_sequencer #(
  parameter int STAGES      = 2,
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  reset_sequencer_if.slave   soft_if,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ?
                        HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_DONE,
    S_SOFT
  } state_t;

  logic [STAGES-1:0]  sync_q;
  logic               rst_sync;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               rdy_q, rdy_d;
  logic               ack_q, ack_d;
  logic               fin;
  logic               soft_go;

  assign rst_sync = sync_q[STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '1;
      rdy_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    rdy_d   = rdy_q;
    ack_d   = 1'b0;
    fin     = 1'b0;
    soft_go = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        // Waits for the synchronised release; after a soft reset it is already high.
        if (rst_sync) begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            cnt_d    = '0;
            idx_d    = '0;
            out_d[0] = 1'b0;
            if (NUM_OUT == 1) fin = 1'b1;
            else state_d = S_RELEASE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_RELEASE: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d        = '0;
          idx_d        = idx_q + IW'(1);
          out_d[idx_d] = 1'b0;
          if (idx_d == IW'(NUM_OUT - 1)) fin = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (soft_if.soft_rst_req) soft_go = 1'b1;
      end
      S_SOFT: begin
`ifdef RESET_SEQ_REVERSE_EN
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d        = '0;
          idx_d        = idx_q - IW'(1);
          out_d[idx_d] = 1'b1;
          if (idx_d == '0) begin
            ack_d   = 1'b1;
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        state_d = S_HOLD;
`endif
      end
      default: state_d = S_HOLD;
    endcase

    // A request pending when the last domain releases is served on that
    // same edge, so ready never shows a one-cycle blip.
    if (fin) begin
      if (soft_if.soft_rst_req) begin
        soft_go = 1'b1;
      end else begin
        state_d = S_DONE;
        rdy_d   = 1'b1;
      end
    end

    if (soft_go) begin
      rdy_d = 1'b0;
      cnt_d = '0;
`ifdef RESET_SEQ_REVERSE_EN
      idx_d              = IW'(NUM_OUT - 1);
      out_d[NUM_OUT-1]   = 1'b1;
      if (NUM_OUT == 1) begin
        ack_d   = 1'b1;
        state_d = S_HOLD;
      end else begin
        state_d = S_SOFT;
      end
`else
      out_d   = '1;
      ack_d   = 1'b1;
      state_d = S_HOLD;
`endif
    end
  end

  assign rst_out              = out_q;
  assign ready                = rdy_q;
  assign soft_if.soft_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed, table-driven bench for reset_sequencer (default parameters).
// Edge numbers count posedges from the first one sampling the relevant stimulus.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rst_out;
  logic       ready;
  int         cyc;
  int         n_cmp;
  int         n_bad;

  reset_sequencer_if sif ();

  reset_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .soft_if (sif),
    .rst_out (rst_out),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic       req;
    logic [2:0] out;
    logic       rdy;
    logic       ack;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int e, input logic req, input logic [2:0] out,
                     input logic rdy, input logic ack);
    vec_t v;
    v.e = e; v.req = req; v.out = out; v.rdy = rdy; v.ack = ack;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all(input string tag, input logic [2:0] out,
                           input logic rdy, input logic ack);
    check({tag, " rst_out"}, {29'd0, rst_out}, {29'd0, out});
    check({tag, " ready"}, {31'd0, ready}, {31'd0, rdy});
    check({tag, " ack"}, {31'd0, sif.soft_rst_ack}, {31'd0, ack});
  endtask

  task automatic run(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      int guard;
      guard = 0;
      while (cyc < vecs[i].e - 1 && guard < 200) begin
        tick();
        guard++;
      end
      sif.soft_rst_req = vecs[i].req;
      tick();
      check_all($sformatf("%s e%0d", tag, vecs[i].e),
                vecs[i].out, vecs[i].rdy, vecs[i].ack);
    end
  endtask

  task automatic por(input string tag);
    rst = 1'b0;
    #1;
    check_all({tag, " async"}, 3'b111, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    cyc = 0;
  endtask

  int t1_lo, t1_hi, t1_mid, t3_lo, t3_hi, t4_lo, t4_hi;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    sif.soft_rst_req = 1'b0;

    t1_lo = vecs.size();
    add(1,  0, 3'b111, 0, 0);
    add(2,  0, 3'b111, 0, 0);
    add(17, 0, 3'b111, 0, 0);
    add(18, 0, 3'b110, 0, 0);
    t1_mid = vecs.size();
    add(21, 0, 3'b110, 0, 0);
    add(22, 0, 3'b100, 0, 0);
    add(25, 0, 3'b100, 0, 0);
    add(26, 0, 3'b000, 1, 0);
    add(30, 0, 3'b000, 1, 0);
    t1_hi = vecs.size();

    t3_lo = vecs.size();
`ifdef RESET_SEQ_REVERSE_EN
    add(1,  1, 3'b100, 0, 0);
    add(4,  1, 3'b100, 0, 0);
    add(5,  1, 3'b110, 0, 0);
    add(8,  1, 3'b110, 0, 0);
    add(9,  0, 3'b111, 0, 1);
    add(10, 0, 3'b111, 0, 0);
    add(24, 0, 3'b111, 0, 0);
    add(25, 0, 3'b110, 0, 0);
    add(29, 0, 3'b100, 0, 0);
    add(33, 0, 3'b000, 1, 0);
`else
    add(1,  1, 3'b111, 0, 1);
    add(2,  0, 3'b111, 0, 0);
    add(16, 0, 3'b111, 0, 0);
    add(17, 0, 3'b110, 0, 0);
    add(21, 0, 3'b100, 0, 0);
    add(25, 0, 3'b000, 1, 0);
`endif
    t3_hi = vecs.size();

    t4_lo = vecs.size();
    add(5,  1, 3'b111, 0, 0);
    add(25, 1, 3'b100, 0, 0);
`ifdef RESET_SEQ_REVERSE_EN
    add(26, 1, 3'b100, 0, 0);
    add(30, 1, 3'b110, 0, 0);
    add(33, 1, 3'b110, 0, 0);
    add(34, 0, 3'b111, 0, 1);
    add(35, 0, 3'b111, 0, 0);
    add(49, 0, 3'b111, 0, 0);
    add(50, 0, 3'b110, 0, 0);
`else
    add(26, 1, 3'b111, 0, 1);
    add(27, 0, 3'b111, 0, 0);
    add(41, 0, 3'b111, 0, 0);
    add(42, 0, 3'b110, 0, 0);
`endif
    t4_hi = vecs.size();

    #1;
    por("t1");
    run("t1", t1_lo, t1_hi);

    cyc = 0;
    run("t3", t3_lo, t3_hi);

    por("t2a");
    run("t2a", t1_lo, t1_mid);
    tick();
    rst = 1'b0;
    #1;
    check_all("t2 mid", 3'b111, 1'b0, 1'b0);
    repeat (2) tick();
    check_all("t2 low", 3'b111, 1'b0, 1'b0);
    rst = 1'b1;
    cyc = 0;
    run("t2b", t1_lo, t1_hi);

    por("t4");
    run("t4", t4_lo, t4_hi);

    tick();
    rst = 1'b0;
    #1;
    check_all("t5 midsoft", 3'b111, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    repeat (40) tick();
    check_all("t6 pre", 3'b000, 1'b1, 1'b0);

    #1;
    rst = 1'b0;
    #1;
    check_all("t6 glitch", 3'b111, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    cyc = 0;
    run("t6", t1_lo, t1_mid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
